// File: rtl/context_sign_merge_pipe_pkg.sv
// Shared defaults and helpers for the JPEG-LS context sign/merge pipeline.
// Also provides a constant multiply that builds to shift-add, so the index needs no DSP.
package context_sign_merge_pipe_pkg;

    localparam int Q_LENGTH_DEF  = 4;
    localparam int Q_RANGE_DEF   = 4;
    localparam int CTX_IDX_W_DEF = 9;
    localparam int CH_W_DEF      = 2;

    // Index arithmetic width. It is far wider than IDX_W+2, so signed partial sums cannot wrap.
    localparam int ACC_W = 32;

    // k is an elaboration-time constant, so this folds to a fixed set of shifted adds.
    function automatic logic signed [ACC_W-1:0] const_mul(input logic signed [ACC_W-1:0] x,
                                                          input int k);
        logic signed [ACC_W-1:0] acc;
        acc = '0;
        for (int b = 0; b < ACC_W; b++) begin
            if (k[b]) acc = acc + (x <<< b);
        end
        return acc;
    endfunction

endpackage

// File: rtl/context_sign_norm.sv
// Sign normalisation of a gradient triplet. The sign comes from the first non-zero Qi.
// Purely combinational, with no handshake. Run-mode and range flags are taken from the raw input.
module context_sign_norm
    import context_sign_merge_pipe_pkg::*;
#(
    parameter int Q_length = Q_LENGTH_DEF,
    parameter int Q_RANGE  = Q_RANGE_DEF
) (
    input  logic signed [Q_length-1:0] q_1,
    input  logic signed [Q_length-1:0] q_2,
    input  logic signed [Q_length-1:0] q_3,
    output logic                       sign,
    output logic signed [Q_length-1:0] qn_1,
    output logic signed [Q_length-1:0] qn_2,
    output logic signed [Q_length-1:0] qn_3,
    output logic                       run_mode,
    output logic                       range_err
);

    function automatic logic out_of_range(input logic signed [Q_length-1:0] q);
        return (int'(q) > Q_RANGE) || (int'(q) < -Q_RANGE);
    endfunction

    logic neg;

    always_comb begin
        neg       = 1'b0;
        run_mode  = (q_1 == '0) && (q_2 == '0) && (q_3 == '0);
        range_err = out_of_range(q_1) | out_of_range(q_2) | out_of_range(q_3);
        if (q_1 != '0)      neg = q_1[Q_length-1];
        else if (q_2 != '0) neg = q_2[Q_length-1];
        else                neg = q_3[Q_length-1];
        // An illegal vector passes through raw, so its sign is forced to 0.
        sign = neg & ~range_err;
        qn_1 = sign ? -q_1 : q_1;
        qn_2 = sign ? -q_2 : q_2;
        qn_3 = sign ? -q_3 : q_3;
    end

endmodule

// File: rtl/context_sign_merge_pipe.sv
// JPEG-LS context sign/merge unit: sign-normalise (S1), then the merged context index (S2).
// Latency is 2 cycles with a throughput of 1/cycle. Full-rate streaming with a combinational in_ready.
// Backpressure: a stage advances when it is empty or the next stage can take its data. flush drops all valids.
module context_sign_merge_pipe
    import context_sign_merge_pipe_pkg::*;
#(
    parameter int Q_length = Q_LENGTH_DEF,
    parameter int Q_RANGE  = Q_RANGE_DEF,
    parameter int IDX_W    = CTX_IDX_W_DEF,
    parameter int CH_W     = CH_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CH_W-1:0]            in_ch,
    input  logic signed [Q_length-1:0] Q_1,
    input  logic signed [Q_length-1:0] Q_2,
    input  logic signed [Q_length-1:0] Q_3,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CH_W-1:0]            out_ch,
    output logic                       sign,
    output logic signed [Q_length-1:0] Qn_1,
    output logic signed [Q_length-1:0] Qn_2,
    output logic signed [Q_length-1:0] Qn_3,
    output logic [IDX_W-1:0]           ctx_idx,
    output logic                       run_mode,
    output logic                       range_err
);

    localparam int R = 2 * Q_RANGE + 1;

    typedef struct packed {
        logic [CH_W-1:0]            ch;
        logic                       sign;
        logic signed [Q_length-1:0] qn_1;
        logic signed [Q_length-1:0] qn_2;
        logic signed [Q_length-1:0] qn_3;
        logic                       run_mode;
        logic                       range_err;
    } s1_t;

    typedef struct packed {
        s1_t              base;
        logic [IDX_W-1:0] ctx;
    } s2_t;

    s1_t  s1_d, s1_q;
    s2_t  s2_q;
    logic v1, v2;
    logic rdy2;

    logic                       n_sign, n_run, n_err;
    logic signed [Q_length-1:0] n_q1, n_q2, n_q3;

    context_sign_norm #(
        .Q_length (Q_length),
        .Q_RANGE  (Q_RANGE)
    ) u_norm (
        .q_1       (Q_1),
        .q_2       (Q_2),
        .q_3       (Q_3),
        .sign      (n_sign),
        .qn_1      (n_q1),
        .qn_2      (n_q2),
        .qn_3      (n_q3),
        .run_mode  (n_run),
        .range_err (n_err)
    );

    always_comb begin
        s1_d           = '0;
        s1_d.ch        = in_ch;
        s1_d.sign      = n_sign;
        s1_d.qn_1      = n_q1;
        s1_d.qn_2      = n_q2;
        s1_d.qn_3      = n_q3;
        s1_d.run_mode  = n_run;
        s1_d.range_err = n_err;
    end

    // Index: Qn_1*R*R + Qn_2*R + Qn_3, evaluated signed and then truncated.
    logic signed [ACC_W-1:0] acc;
    logic [IDX_W-1:0]        ctx_d;
    logic                    unused_acc_hi;

    always_comb begin
        acc = const_mul(ACC_W'($signed(s1_q.qn_1)), R * R)
            + const_mul(ACC_W'($signed(s1_q.qn_2)), R)
            + ACC_W'($signed(s1_q.qn_3));
        ctx_d = s1_q.range_err ? '0 : acc[IDX_W-1:0];
    end

    assign unused_acc_hi = ^acc[ACC_W-1:IDX_W];

    assign rdy2      = !v2 || out_ready;
    assign in_ready  = !v1 || rdy2;
    assign out_valid = v2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            s1_q <= '0;
            s2_q <= '0;
        end else if (flush) begin
            // flush beats a same-cycle input transfer. Data registers keep their contents.
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (rdy2) begin
                v2 <= v1;
                if (v1) begin
                    s2_q.base <= s1_q;
                    s2_q.ctx  <= ctx_d;
                end
            end
            if (in_ready) begin
                v1 <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
        end
    end

    assign out_ch    = s2_q.base.ch;
    assign sign      = s2_q.base.sign;
    assign Qn_1      = s2_q.base.qn_1;
    assign Qn_2      = s2_q.base.qn_2;
    assign Qn_3      = s2_q.base.qn_3;
    assign ctx_idx   = s2_q.ctx;
    assign run_mode  = s2_q.base.run_mode;
    assign range_err = s2_q.base.range_err;

endmodule

// File: tb/tb_context_sign_merge_pipe.sv
// Bench for context_sign_merge_pipe: a vector table, stall/reset/flush sequences and an exhaustive legal sweep.
// Expected results are queued on each accepted input and compared whenever the unit presents an output.
module tb_context_sign_merge_pipe;

    typedef struct packed {
        logic [1:0] ch;
        logic       sign;
        logic [3:0] qn1;
        logic [3:0] qn2;
        logic [3:0] qn3;
        logic [8:0] ctx;
        logic       run;
        logic       rerr;
    } exp_t;

    typedef struct packed {
        logic [3:0] q1;
        logic [3:0] q2;
        logic [3:0] q3;
        exp_t       e;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [1:0] in_ch, out_ch;
    logic [3:0] Q_1, Q_2, Q_3, Qn_1, Qn_2, Qn_3;
    logic [8:0] ctx_idx;
    logic       sign, run_mode, range_err;

    exp_t sb[$];
    exp_t cur_exp;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_out   = 0;
    bit   sweep_on = 0;
    bit   in_ready_low_seen = 0;
    int   hits[512];
    vec_t tbl[11];

    context_sign_merge_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .Q_1       (Q_1),
        .Q_2       (Q_2),
        .Q_3       (Q_3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .sign      (sign),
        .Qn_1      (Qn_1),
        .Qn_2      (Qn_2),
        .Qn_3      (Qn_3),
        .ctx_idx   (ctx_idx),
        .run_mode  (run_mode),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic exp_t got_now();
        return {out_ch, sign, Qn_1, Qn_2, Qn_3, ctx_idx, run_mode, range_err};
    endfunction

    function automatic exp_t model(input logic [1:0] ch, input logic [3:0] a, input logic [3:0] b,
                                   input logic [3:0] c);
        exp_t e;
        int   q[3];
        int   n[3];
        bit   neg, err;
        q[0] = int'($signed(a));
        q[1] = int'($signed(b));
        q[2] = int'($signed(c));
        err = 0;
        for (int k = 0; k < 3; k++) if (q[k] > 4 || q[k] < -4) err = 1;
        if (q[0] != 0)      neg = q[0] < 0;
        else if (q[1] != 0) neg = q[1] < 0;
        else                neg = q[2] < 0;
        if (err) neg = 0;
        for (int k = 0; k < 3; k++) n[k] = neg ? -q[k] : q[k];
        e.ch   = ch;
        e.sign = neg;
        e.qn1  = 4'(n[0]);
        e.qn2  = 4'(n[1]);
        e.qn3  = 4'(n[2]);
        e.ctx  = err ? 9'd0 : 9'(n[0] * 81 + n[1] * 9 + n[2]);
        e.run  = (q[0] == 0) && (q[1] == 0) && (q[2] == 0);
        e.rerr = err;
        return e;
    endfunction

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [1:0] ch, input exp_t e);
        int waitc;
        bit acc;
        waitc = 0;
        acc = 0;
        Q_1 = a; Q_2 = b; Q_3 = c; in_ch = ch;
        cur_exp = e;
        in_valid = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                waitc++;
                if (waitc > 100) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL send_timeout: in_ready stuck low");
                    acc = 1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Handshakes are observed at the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst_n && !flush) begin
            if (in_valid && in_ready) sb.push_back(cur_exp);
            if (in_valid && !in_ready) in_ready_low_seen = 1;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %h required none", got_now());
                end else if (out_ready) begin
                    chk("out_xfer", 32'(got_now()), 32'(sb.pop_front()));
                    n_out++;
                    if (sweep_on) hits[ctx_idx]++;
                end else begin
                    chk("stall_hold", 32'(got_now()), 32'(sb[0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        //            q1    q2    q3    ch    sg   qn1   qn2   qn3   ctx     run   rerr
        tbl[0]  = {4'h0, 4'hD, 4'h2, 2'd0, 1'b1, 4'h0, 4'h3, 4'hE, 9'd25,  1'b0, 1'b0};
        tbl[1]  = {4'h2, 4'hF, 4'h4, 2'd1, 1'b0, 4'h2, 4'hF, 4'h4, 9'd157, 1'b0, 1'b0};
        tbl[2]  = {4'hC, 4'hC, 4'hC, 2'd2, 1'b1, 4'h4, 4'h4, 4'h4, 9'd364, 1'b0, 1'b0};
        tbl[3]  = {4'h0, 4'h0, 4'h0, 2'd3, 1'b0, 4'h0, 4'h0, 4'h0, 9'd0,   1'b1, 1'b0};
        tbl[4]  = {4'h0, 4'h0, 4'hF, 2'd0, 1'b1, 4'h0, 4'h0, 4'h1, 9'd1,   1'b0, 1'b0};
        tbl[5]  = {4'h5, 4'h0, 4'h0, 2'd1, 1'b0, 4'h5, 4'h0, 4'h0, 9'd0,   1'b0, 1'b1};
        tbl[6]  = {4'h1, 4'h1, 4'h1, 2'd2, 1'b0, 4'h1, 4'h1, 4'h1, 9'd91,  1'b0, 1'b0};
        tbl[7]  = {4'h8, 4'h1, 4'h1, 2'd3, 1'b0, 4'h8, 4'h1, 4'h1, 9'd0,   1'b0, 1'b1};
        tbl[8]  = {4'hF, 4'h4, 4'hC, 2'd0, 1'b1, 4'h1, 4'hC, 4'h4, 9'd49,  1'b0, 1'b0};
        tbl[9]  = {4'h0, 4'h4, 4'h0, 2'd1, 1'b0, 4'h0, 4'h4, 4'h0, 9'd36,  1'b0, 1'b0};
        tbl[10] = {4'h0, 4'hB, 4'h0, 2'd2, 1'b0, 4'h0, 4'hB, 4'h0, 9'd0,   1'b0, 1'b1};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        Q_1 = '0; Q_2 = '0; Q_3 = '0; in_ch = '0; cur_exp = '0;
        #3;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_regs", 32'(got_now()), 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // One sample: valid must appear on the second edge after acceptance, not the first.
        send(tbl[0].q1, tbl[0].q2, tbl[0].q3, tbl[0].e.ch, tbl[0].e);
        chk("latency_edge1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("latency_edge2", 32'(out_valid), 32'd1);
        drain();

        for (int i = 0; i < 11; i++) send(tbl[i].q1, tbl[i].q2, tbl[i].q3, tbl[i].e.ch, tbl[i].e);
        drain();

        // Six back-to-back samples while the consumer stalls for three cycles.
        n_out = 0;
        in_ready_low_seen = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(4'(i - 2), 4'((i % 3) - 1), 4'(1 - i), 2'(i),
                         model(2'(i), 4'(i - 2), 4'((i % 3) - 1), 4'(1 - i)));
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_out_count", 32'(n_out), 32'd6);
        chk("stall_in_ready_low", 32'(in_ready_low_seen), 32'd1);

        // Reset while both stages hold data.
        out_ready = 1'b0;
        send(4'h1, 4'h2, 4'h3, 2'd1, model(2'd1, 4'h1, 4'h2, 4'h3));
        send(4'hE, 4'h0, 4'h1, 2'd2, model(2'd2, 4'hE, 4'h0, 4'h1));
        chk("full_in_ready_low", 32'(in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", 32'(out_valid), 32'd0);
        chk("async_reset_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_no_out", 32'(out_valid), 32'd0);

        // flush beats a same-cycle input.
        Q_1 = 4'h1; Q_2 = 4'h2; Q_3 = 4'h3; in_ch = 2'd3;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("flush_no_out_1", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("flush_no_out_2", 32'(out_valid), 32'd0);
        chk("flush_sb_empty", 32'(sb.size()), 32'd0);

        // Every legal triplet. Each index must be hit by exactly one {v, -v} pair.
        for (int k = 0; k < 512; k++) hits[k] = 0;
        sweep_on = 1;
        for (int a = -4; a <= 4; a++)
            for (int b = -4; b <= 4; b++)
                for (int c = -4; c <= 4; c++)
                    send(4'(a), 4'(b), 4'(c), 2'(a + b + c),
                         model(2'(a + b + c), 4'(a), 4'(b), 4'(c)));
        drain();
        sweep_on = 0;
        bad = 0;
        for (int k = 0; k < 512; k++) begin
            if (k == 0 && hits[k] != 1) bad++;
            else if (k > 0 && k <= 364 && hits[k] != 2) bad++;
            else if (k > 364 && hits[k] != 0) bad++;
        end
        chk("ctx_pair_unique", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
